ahb_sram_slave: RTL and testbench

//  AHB-Lite responder (slave end of the bus) backed by a word-addressed on-chip SRAM.
//  - Accepts pipelined single transfers from a master; drives HRDATA/HRESP/HREADY_OUT.
//  - Inserts a configurable number of wait states per transfer.
//  - Signals a two-cycle ERROR response for misaligned or out-of-range addresses.
//  - Sits behind the address decoder, which drives HSEL and returns HREADY_IN from the mux.

---
 rtl/ahb_sram_slave_if.sv | 23 ++
 rtl/ahb_sram_slave.sv | 79 +++++++
 tb/tb_ahb_sram_slave.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite bus bundle between a master/decoder and the SRAM responder.
interface ahb_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic                  HREADY_IN;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic [1:0]            HRESP;
   logic                  HREADY_OUT;
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HREADY_IN, HWDATA,
      output HRDATA, HRESP, HREADY_OUT
   );
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
      input  HRDATA, HRESP, HREADY_OUT, HREADY_IN
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a word-addressed SRAM with configurable wait states
// and a two-cycle ERROR response for misaligned or out-of-range addresses.
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic             HCLK,
   input  logic             HRESET,
   ahb_sram_slave_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BSW   = $clog2(BYTES);
   localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t                state_q, state_d, target;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  write_q, write_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  open_q, accept, addr_err;
   logic                  unused_htrans;

   assign unused_htrans = bus.HTRANS[0];
   // Address phases are only honoured while the bus can advance (never in WAIT or ERR1).
   assign open_q    = state_q inside {S_IDLE, S_DATA, S_ERR2};
   assign accept    = open_q && bus.HSEL && bus.HREADY_IN && bus.HTRANS[1];
   assign word_addr = bus.HADDR >> BSW;
   assign addr_err  = ((bus.HADDR & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                      (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
   assign target    = addr_err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_DATA;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      write_d = write_q;
      cnt_d   = '0;
      case (state_q)
         S_WAIT: begin
            state_d = (cnt_q == 4'(WAIT_STATES)) ? S_DATA : S_WAIT;
            cnt_d   = (state_d == S_WAIT) ? cnt_q + 4'd1 : 4'd0;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = accept ? target : S_IDLE;
      endcase
      if (accept) begin
         idx_d   = word_addr[IW-1:0];
         write_d = bus.HWRITE;
         cnt_d   = (target == S_WAIT) ? 4'd1 : 4'd0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
      end
   end

   // SRAM is deliberately not reset; a reset edge suppresses the pending write.
   always_ff @(posedge HCLK) begin
      if (!HRESET && state_q == S_DATA && write_q) mem[idx_q] <= bus.HWDATA;
   end

   assign bus.HREADY_OUT = !(state_q inside {S_WAIT, S_ERR1});
   assign bus.HRESP      = (state_q inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
   assign bus.HRDATA     = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven scoreboard bench for the zero-wait responder plus
// hand-written wait-state, error and reset sequences on a WAIT_STATES=2 instance.
module tb_ahb_sram_slave;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
   assign b0.HREADY_IN = b0.HREADY_OUT;
   assign b2.HREADY_IN = b2.HREADY_OUT;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
      dut0 (.HCLK(clk), .HRESET(rst), .bus(b0));
   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2))
      dut2 (.HCLK(clk), .HRESET(rst), .bus(b2));

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;
   typedef struct {
      int          id;
      logic        wr;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   localparam int NV = 20;
   vec_t vecs [NV];
   exp_t sbq [$];
   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [31:0] addr,
                               logic [31:0] wdata, logic err, logic [31:0] rdata);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.addr = addr;
      v.wdata = wdata; v.err = err; v.rdata = rdata;
      return v;
   endfunction

   task automatic drive0(input logic sel, input logic [1:0] trans, input logic wr, input logic [31:0] addr);
      b0.HSEL = sel; b0.HTRANS = trans; b0.HWRITE = wr; b0.HADDR = addr;
   endtask

   task automatic drive2(input logic sel, input logic [1:0] trans, input logic wr, input logic [31:0] addr);
      b2.HSEL = sel; b2.HTRANS = trans; b2.HWRITE = wr; b2.HADDR = addr;
   endtask

   task automatic chk2(input string name, input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
      chk({name, " ready"}, 32'(b2.HREADY_OUT), 32'(rdy));
      chk({name, " resp"},  32'(b2.HRESP),      32'(resp));
      chk({name, " rdata"}, b2.HRDATA,          rdata);
   endtask

   initial begin
      logic [31:0] prev_wdata;
      exp_t e;
      vecs[0]  = mk(1, 2'b10, 1, 32'h0000_0000, 32'h0000_1111, 0, 32'h0);
      vecs[1]  = mk(1, 2'b10, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0);
      vecs[2]  = mk(1, 2'b10, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF);
      vecs[3]  = mk(1, 2'b11, 1, 32'h0000_0014, 32'h1234_5678, 0, 32'h0);
      vecs[4]  = mk(1, 2'b10, 1, 32'h0000_03FC, 32'hCAFE_F00D, 0, 32'h0);
      vecs[5]  = mk(1, 2'b10, 0, 32'h0000_0014, 32'h0,         0, 32'h1234_5678);
      vecs[6]  = mk(1, 2'b11, 0, 32'h0000_03FC, 32'h0,         0, 32'hCAFE_F00D);
      vecs[7]  = mk(1, 2'b10, 0, 32'h0000_0002, 32'h0,         1, 32'h0);
      vecs[8]  = mk(1, 2'b10, 1, 32'h0000_0400, 32'hBAD0_BAD0, 1, 32'h0);
      vecs[9]  = mk(1, 2'b10, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_1111);
      vecs[10] = mk(1, 2'b01, 1, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0);
      vecs[11] = mk(0, 2'b10, 1, 32'h0000_0000, 32'hEEEE_EEEE, 0, 32'h0);
      vecs[12] = mk(1, 2'b00, 1, 32'h0000_0000, 32'hDDDD_DDDD, 0, 32'h0);
      vecs[13] = mk(1, 2'b10, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_1111);
      vecs[14] = mk(1, 2'b10, 1, 32'h0000_0020, 32'hA5A5_5A5A, 0, 32'h0);
      vecs[15] = mk(1, 2'b10, 0, 32'h0000_0020, 32'h0,         0, 32'hA5A5_5A5A);
      vecs[16] = mk(1, 2'b10, 0, 32'h0000_03FD, 32'h0,         1, 32'h0);
      vecs[17] = mk(1, 2'b10, 0, 32'h8000_0000, 32'h0,         1, 32'h0);
      vecs[18] = mk(0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 32'h0);
      vecs[19] = mk(0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 32'h0);

      rst = 1'b1;
      drive0(0, 2'b00, 0, 32'h0); b0.HWDATA = '0;
      drive2(0, 2'b00, 0, 32'h0); b2.HWDATA = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst0 ready", 32'(b0.HREADY_OUT), 32'd1);
      chk("rst0 resp",  32'(b0.HRESP),      32'd0);
      chk("rst0 rdata", b0.HRDATA,          32'd0);
      chk2("rst2", 1'b1, 2'b00, 32'h0);
      rst = 1'b0;
      tick();

      // Zero-wait instance: address phase of vector i overlaps the data phase of the previous transfer.
      prev_wdata = '0;
      for (int i = 0; i < NV; i++) begin
         if (sbq.size() > 0 && sbq[0].err) begin
            drive0(0, 2'b00, 0, 32'h0);
            b0.HWDATA = prev_wdata;
            #1;
            chk($sformatf("v%0d err1 ready", sbq[0].id), 32'(b0.HREADY_OUT), 32'd0);
            chk($sformatf("v%0d err1 resp",  sbq[0].id), 32'(b0.HRESP),      32'd1);
            tick();
         end
         drive0(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].addr);
         b0.HWDATA = prev_wdata;
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("v%0d ready", e.id), 32'(b0.HREADY_OUT), 32'd1);
            chk($sformatf("v%0d resp",  e.id), 32'(b0.HRESP),      e.err ? 32'd1 : 32'd0);
            chk($sformatf("v%0d rdata", e.id), b0.HRDATA,          (e.err || e.wr) ? 32'h0 : e.rdata);
         end else begin
            chk($sformatf("idle%0d ready", i), 32'(b0.HREADY_OUT), 32'd1);
            chk($sformatf("idle%0d resp",  i), 32'(b0.HRESP),      32'd0);
            chk($sformatf("idle%0d rdata", i), b0.HRDATA,          32'h0);
         end
         if (vecs[i].sel && vecs[i].trans[1]) begin
            e.id = i; e.wr = vecs[i].wr; e.err = vecs[i].err; e.rdata = vecs[i].rdata;
            sbq.push_back(e);
         end
         prev_wdata = vecs[i].wdata;
         tick();
      end
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);

      // Two-wait-state instance: write then read of word 1.
      drive2(1, 2'b10, 1, 32'h0000_0004);
      tick();
      drive2(0, 2'b00, 0, 32'h0);
      b2.HWDATA = 32'h0BAD_F00D;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk2($sformatf("ws wr c%0d", k), k == 2, 2'b00, 32'h0);
         if (k == 2) drive2(1, 2'b10, 0, 32'h0000_0004);
         tick();
      end
      drive2(0, 2'b00, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk2($sformatf("ws rd c%0d", k), k == 2, 2'b00, (k == 2) ? 32'h0BAD_F00D : 32'h0);
         tick();
      end

      // Reset during the wait phase of a write must abort it.
      drive2(1, 2'b10, 1, 32'h0000_0004);
      tick();
      drive2(0, 2'b00, 0, 32'h0);
      b2.HWDATA = 32'hFFFF_0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk2("ws rst idle", 1'b1, 2'b00, 32'h0);
      tick();
      drive2(1, 2'b10, 0, 32'h0000_0004);
      tick();
      drive2(0, 2'b00, 0, 32'h0);
      tick();
      tick();
      chk2("ws rst readback", 1'b1, 2'b00, 32'h0BAD_F00D);
      tick();

      // Errors skip wait states even when WAIT_STATES > 0.
      drive2(1, 2'b10, 0, 32'h0000_0006);
      tick();
      drive2(0, 2'b00, 0, 32'h0);
      #1;
      chk2("ws err1", 1'b0, 2'b01, 32'h0);
      tick();
      chk2("ws err2", 1'b1, 2'b01, 32'h0);
      tick();
      chk2("ws err idle", 1'b1, 2'b00, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
